// File: rtl/rgb_axis_packer.sv
// Colour-mapper pixel stream to AXI4-Stream video master with a skid FIFO,
// early stall, line/frame markers and a sticky overflow flag.
module rgb_axis_packer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int SLACK      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    input  logic        valid_in,
    output logic        stall,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int OW = AW + 2;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [OW-1:0] STALL_TH = OW'(FIFO_DEPTH + 1 - SLACK);
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_next;
    logic [OW-1:0] occ_next;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic pop, reg_load, fifo_empty, fifo_full;
    logic bypass, fifo_rd, fifo_wr, drop, tvalid_next;
    logic x_end, y_end;

    always_comb begin
        pop        = m_axis_tvalid & m_axis_tready;
        reg_load   = ~m_axis_tvalid | pop;
        fifo_empty = (cnt == '0);
        fifo_full  = (cnt == FULL_CNT);
        // An empty FIFO is skipped so a lone pixel reaches tvalid one cycle later.
        bypass     = reg_load & fifo_empty & valid_in;
        fifo_rd    = reg_load & ~fifo_empty;
        // A full FIFO still accepts when its head moves to the output register.
        fifo_wr    = valid_in & ~bypass & (~fifo_full | fifo_rd);
        drop       = valid_in & ~bypass & fifo_full & ~fifo_rd;
        cnt_next   = cnt + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
        tvalid_next = reg_load ? (fifo_rd | bypass) : 1'b1;
        occ_next   = OW'(cnt_next) + OW'(tvalid_next);
        x_end      = (x == X_LAST);
        y_end      = (y == Y_LAST);
    end

    // Markers derive from the position of the held pixel, so they cannot move until a pop.
    assign m_axis_tuser = m_axis_tvalid & (x == '0) & (y == '0);
    assign m_axis_tlast = m_axis_tvalid & x_end;

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= rgb_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            x             <= '0;
            y             <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            stall         <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt_next;

            if (reg_load) begin
                m_axis_tvalid <= fifo_rd | bypass;
                if (fifo_rd)     m_axis_tdata <= mem[rd_ptr];
                else if (bypass) m_axis_tdata <= rgb_in;
            end

            frame_done <= pop & x_end & y_end;
            if (pop) begin
                if (x_end) begin
                    x <= '0;
                    y <= y_end ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end

            if (drop) overflow <= 1'b1;
            stall <= (occ_next >= STALL_TH);
        end
    end
endmodule

// File: tb/tb_rgb_axis_packer.sv
// Scoreboard bench for rgb_axis_packer: directed streams push expected beats,
// a negedge monitor pops and compares on every AXI handshake.
module tb_rgb_axis_packer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 16;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        valid_in = 1'b0;
    logic        stall;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        frame_done;
    logic        overflow;

    rgb_axis_packer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .SLACK(S)) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .valid_in(valid_in), .stall(stall),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
        logic        eof;
    } beat_t;

    beat_t q[$];
    int checks = 0, failures = 0;
    int ex = 0, ey = 0;
    int tuser_cnt = 0, tlast_cnt = 0, fd_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference position model: markers follow the order of accepted pixels.
    task automatic expect_px(input logic [23:0] d);
        beat_t b;
        b.d   = d;
        b.u   = (ex == 0 && ey == 0);
        b.l   = (ex == W-1);
        b.eof = (ex == W-1 && ey == H-1);
        q.push_back(b);
        if (ex == W-1) begin
            ex = 0;
            ey = (ey == H-1) ? 0 : ey + 1;
        end else begin
            ex++;
        end
    endtask

    task automatic cyc(input logic v, input logic [23:0] d, input logic rdy);
        @(posedge clk); #1;
        valid_in = v; rgb_in = d; m_axis_tready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 0; valid_in = 0; m_axis_tready = 0;
        q.delete(); ex = 0; ey = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tdata"}, m_axis_tdata, 0);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tuser"}, m_axis_tuser, 0);
        check({tag, "_tlast"}, m_axis_tlast, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        @(posedge clk); #1;
        valid_in = 0; m_axis_tready = 1;
        while (q.size() > 0 && n < budget) begin
            @(posedge clk); n++;
        end
        if (q.size() > 0) begin
            checks++; failures++;
            $display("FAIL %s_drain_timeout remaining=%0d expected=0", tag, q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pop, AXI hold stability and frame_done timing.
    logic  prev_hold = 0, prev_eof = 0;
    logic [25:0] prev_beat = '0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 0; prev_eof = 0;
        end else begin
            if (frame_done || prev_eof) check("frame_done_pulse", frame_done, prev_eof);
            if (frame_done) fd_cnt++;
            if (prev_hold) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev_beat);
            end
            prev_eof = 0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_beat tdata=%0h expected=none", m_axis_tdata);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check("tdata", m_axis_tdata, e.d);
                    check("tuser", m_axis_tuser, e.u);
                    check("tlast", m_axis_tlast, e.l);
                    prev_eof = e.eof;
                end
                if (m_axis_tuser) tuser_cnt++;
                if (m_axis_tlast) tlast_cnt++;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_beat = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    initial begin
        int sent, n;
        logic [23:0] d;
        // Reset state
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset");
        do_reset();

        // 1: one 4x2 frame back to back with tready=1
        tuser_cnt = 0; tlast_cnt = 0; fd_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 24'(i), 1);
            expect_px(24'(i));
        end
        drain("t1", 50);
        check("t1_tuser_count", tuser_cnt, 1);
        check("t1_tlast_count", tlast_cnt, 2);
        check("t1_frame_done_count", fd_cnt, 1);
        check("t1_overflow", overflow, 0);

        // 2: held head under backpressure, stall at occupancy 13
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k > 0) begin
                check("t2_stall", stall, (k >= 13) ? 1 : 0);
                check("t2_tvalid", m_axis_tvalid, 1);
                check("t2_tdata", m_axis_tdata, 24'hABCDEF);
            end
            m_axis_tready = 0;
            if (k < 14) begin
                d = (k == 0) ? 24'hABCDEF : 24'h100000 + 24'(k);
                valid_in = 1; rgb_in = d;
                expect_px(d);
            end else begin
                valid_in = 0;
            end
        end
        drain("t2", 100);
        check("t2_stall_after_drain", stall, 0);

        // 3: stall ignored, 20 pushes, only 17 retained
        do_reset();
        for (int i = 0; i < 20; i++) begin
            d = 24'h300000 + 24'(i);
            cyc(1, d, 0);
            if (i < 17) expect_px(d);
        end
        cyc(0, 0, 0);
        @(posedge clk); #1;
        check("t3_overflow", overflow, 1);
        check("t3_stall", stall, 1);
        repeat (3) @(posedge clk);
        #1 check("t3_overflow_sticky", overflow, 1);
        drain("t3", 100);
        check("t3_overflow_after_drain", overflow, 1);

        // 4: full FIFO, simultaneous pop and push
        do_reset();
        for (int i = 0; i < 17; i++) begin
            d = 24'h400000 + 24'(i);
            cyc(1, d, 0);
            expect_px(d);
        end
        cyc(1, 24'h4000FF, 1);
        expect_px(24'h4000FF);
        cyc(0, 0, 0);
        @(posedge clk); #1;
        check("t4_overflow", overflow, 0);
        check("t4_stall", stall, 1);
        drain("t4", 100);
        check("t4_overflow_after_drain", overflow, 0);

        // 5: random tready / valid over 3 frames, upstream honours stall
        do_reset();
        tuser_cnt = 0; tlast_cnt = 0; fd_cnt = 0;
        sent = 0; n = 0;
        while ((sent < 3*W*H || q.size() > 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
            m_axis_tready = 1'($urandom_range(0, 1));
            if (sent < 3*W*H && $urandom_range(0, 1) == 1 && !stall) begin
                d = 24'($urandom);
                valid_in = 1; rgb_in = d;
                expect_px(d);
                sent++;
            end else begin
                valid_in = 0;
            end
        end
        drain("t5", 100);
        check("t5_tuser_count", tuser_cnt, 3);
        check("t5_tlast_count", tlast_cnt, 3*H);
        check("t5_frame_done_count", fd_cnt, 3);
        check("t5_overflow", overflow, 0);

        // 6: asynchronous reset mid-frame, next pixel restarts the frame
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = 24'h600000 + 24'(i);
            cyc(1, d, 1);
            expect_px(d);
        end
        for (int i = 5; i < 8; i++) begin
            cyc(1, 24'h600000 + 24'(i), 0);
        end
        @(posedge clk); #3;
        reset = 0; valid_in = 0;
        #1 check_outputs_zero("t6_async");
        q.delete(); ex = 0; ey = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        cyc(1, 24'h123456, 1);
        expect_px(24'h123456);
        drain("t6", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
